// File: rtl/enc_seq_pkg.sv
// Shared types for the encoder measurement sequencer: FSM states, error codes
// and a width helper for the disarm counter.
package enc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_WAIT_VLD = 3'd3,
    S_OUTPUT   = 3'd4,
    S_DISARM   = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ABORT   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } seq_err_e;

  function automatic int dis_w(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/enc_seq_timer.sv
// Loadable down-counter used to bound the READY/VALID waits.
// A load of zero leaves the timer idle, so it never expires.
module enc_seq_timer #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_exp
);

  logic [W-1:0] r_cnt;
  logic         r_run;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_val;
      r_run <= |i_val;
    end else if (i_en && r_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_exp = r_run && (r_cnt == '0);

endmodule

// File: rtl/enc_meas_seq.sv
// Measurement sequencer: arms both encoder counters, captures the two counts
// per run and hands each pair out over valid/ready. Wait timeouts are built
// only when ENC_SEQ_TIMEOUT_EN is defined.
module enc_meas_seq
  import enc_seq_pkg::*;
#(
  parameter int CNT_W      = 64,
  parameter int RUNS_W     = 16,
  parameter int TO_W       = 32,
  parameter int DISARM_CYC = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              I_START,
  input  logic              I_ABORT,
  input  logic              I_SEL_CFG,
  input  logic [RUNS_W-1:0] I_RUNS,
  input  logic [TO_W-1:0]   I_TIMEOUT,
  output logic              O_ARM,
  output logic              O_SEL,
  input  logic              I_READY_0,
  input  logic              I_READY_1,
  input  logic              I_VALID_0,
  input  logic              I_VALID_1,
  input  logic              I_OVERFLOW_0,
  input  logic              I_OVERFLOW_1,
  input  logic [CNT_W-1:0]  I_CNT_A0,
  input  logic [CNT_W-1:0]  I_CNT_A1,
  output logic              O_RES_VALID,
  input  logic              I_RES_READY,
  output logic [CNT_W-1:0]  O_RES_CNT0,
  output logic [CNT_W-1:0]  O_RES_CNT1,
  output logic [RUNS_W-1:0] O_RES_IDX,
  output logic [1:0]        O_RES_OVF,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic [1:0]        O_ERR
);

  localparam int              DIS_W    = dis_w(DISARM_CYC);
  localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISARM_CYC - 1);

  seq_state_e        r_state, w_nxt;
  seq_err_e          r_err, w_err;
  logic              r_arm, w_arm;
  logic              r_sel, w_sel;
  logic [RUNS_W-1:0] r_runs, w_runs;
  logic [RUNS_W-1:0] r_idx, w_idx;
  logic [CNT_W-1:0]  r_cnt0, w_cnt0, r_cnt1, w_cnt1;
  logic              r_got0, w_got0, r_got1, w_got1;
  logic [1:0]        r_ovf, w_ovf;
  logic              r_rv, w_rv;
  logic              r_done, w_done;
  logic              r_busy;
  logic              r_stop, w_stop;
  logic [DIS_W-1:0]  r_dis, w_dis;
  logic              w_kill;
  seq_err_e          w_kill_err;
  logic              w_tmr_exp;

`ifdef ENC_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] r_timeout;
  logic            w_tmr_load, w_tmr_en;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                              r_timeout <= '0;
    else if ((r_state == S_IDLE) && I_START) r_timeout <= I_TIMEOUT;
  end

  // Reload on every entry into a wait state so each wait gets the full budget.
  assign w_tmr_load = ((r_state == S_ARM) && (w_nxt == S_WAIT_RDY)) ||
                      ((r_state == S_WAIT_RDY) && (w_nxt == S_WAIT_VLD));
  assign w_tmr_en   = (r_state == S_WAIT_RDY) || (r_state == S_WAIT_VLD);

  enc_seq_timer #(.W(TO_W)) u_tmr (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .i_load (w_tmr_load),
    .i_val  (r_timeout),
    .i_en   (w_tmr_en),
    .o_exp  (w_tmr_exp)
  );
`else
  logic w_unused_to;
  assign w_unused_to = ^I_TIMEOUT;
  assign w_tmr_exp   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_err      = r_err;
    w_arm      = r_arm;
    w_sel      = r_sel;
    w_runs     = r_runs;
    w_idx      = r_idx;
    w_cnt0     = r_cnt0;
    w_cnt1     = r_cnt1;
    w_got0     = r_got0;
    w_got1     = r_got1;
    w_ovf      = r_ovf;
    w_rv       = r_rv;
    w_done     = 1'b0;
    w_stop     = r_stop;
    w_dis      = r_dis;
    w_kill     = 1'b0;
    w_kill_err = ERR_NONE;
    case (r_state)
      S_IDLE: if (I_START) begin
        w_sel  = I_SEL_CFG;
        w_runs = I_RUNS;
        w_err  = ERR_NONE;
        w_idx  = '0;
        w_stop = 1'b0;
        if (I_RUNS == '0) w_done = 1'b1;
        else begin
          w_nxt = S_ARM;
          w_arm = 1'b1;
        end
      end
      S_ARM: begin
        w_got0 = 1'b0;
        w_got1 = 1'b0;
        w_ovf  = '0;
        if (I_ABORT) begin
          w_kill     = 1'b1;
          w_kill_err = ERR_ABORT;
        end else begin
          w_nxt = S_WAIT_RDY;
          w_arm = 1'b1;
        end
      end
      S_WAIT_RDY: begin
        w_ovf = r_ovf | {I_OVERFLOW_1, I_OVERFLOW_0};
        if (I_ABORT) begin
          w_kill     = 1'b1;
          w_kill_err = ERR_ABORT;
        end else if (I_READY_0 && I_READY_1) begin
          w_nxt = S_WAIT_VLD;
        end else if (w_tmr_exp) begin
          w_kill     = 1'b1;
          w_kill_err = ERR_TIMEOUT;
        end
      end
      S_WAIT_VLD: begin
        w_ovf = r_ovf | {I_OVERFLOW_1, I_OVERFLOW_0};
        if (I_ABORT) begin
          w_kill     = 1'b1;
          w_kill_err = ERR_ABORT;
        end else begin
          // First VALID cycle per channel wins; later counter values are ignored.
          if (I_VALID_0 && !r_got0) begin
            w_got0 = 1'b1;
            w_cnt0 = I_CNT_A0;
          end
          if (I_VALID_1 && !r_got1) begin
            w_got1 = 1'b1;
            w_cnt1 = I_CNT_A1;
          end
          if (w_got0 && w_got1) begin
            w_nxt = S_OUTPUT;
            w_rv  = 1'b1;
          end else if (w_tmr_exp) begin
            w_kill     = 1'b1;
            w_kill_err = ERR_TIMEOUT;
          end
        end
      end
      S_OUTPUT: begin
        if (I_ABORT) begin
          w_stop = 1'b1;
          w_err  = ERR_ABORT;
        end
        if (I_RES_READY) begin
          w_rv  = 1'b0;
          w_arm = 1'b0;
          w_dis = '0;
          w_nxt = S_DISARM;
        end
      end
      S_DISARM: begin
        if (I_ABORT && !r_stop) begin
          w_stop = 1'b1;
          w_err  = ERR_ABORT;
        end
        w_dis = r_dis + DIS_W'(1);
        if (r_dis == DIS_LAST) begin
          w_idx = r_idx + RUNS_W'(1);
          if (w_stop) w_nxt = S_IDLE;
          else if (w_idx == r_runs) begin
            w_nxt  = S_IDLE;
            w_done = 1'b1;
          end else w_nxt = S_ARM;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_kill) begin
      w_nxt  = S_DISARM;
      w_arm  = 1'b0;
      w_stop = 1'b1;
      w_err  = w_kill_err;
      w_dis  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_err  <= ERR_NONE;
      r_arm  <= 1'b0;
      r_sel  <= 1'b0;
      r_runs <= '0;
      r_idx  <= '0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_got0 <= 1'b0;
      r_got1 <= 1'b0;
      r_ovf  <= '0;
      r_rv   <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_stop <= 1'b0;
      r_dis  <= '0;
    end else begin
      r_err  <= w_err;
      r_arm  <= w_arm;
      r_sel  <= w_sel;
      r_runs <= w_runs;
      r_idx  <= w_idx;
      r_cnt0 <= w_cnt0;
      r_cnt1 <= w_cnt1;
      r_got0 <= w_got0;
      r_got1 <= w_got1;
      r_ovf  <= w_ovf;
      r_rv   <= w_rv;
      r_done <= w_done;
      r_busy <= (w_nxt != S_IDLE);
      r_stop <= w_stop;
      r_dis  <= w_dis;
    end
  end

  assign O_ARM       = r_arm;
  assign O_SEL       = r_sel;
  assign O_RES_VALID = r_rv;
  assign O_RES_CNT0  = r_cnt0;
  assign O_RES_CNT1  = r_cnt1;
  assign O_RES_IDX   = r_idx;
  assign O_RES_OVF   = r_ovf;
  assign O_BUSY      = r_busy;
  assign O_DONE      = r_done;
  assign O_ERR       = r_err;

endmodule
